// File: rtl/acs_unit_param.sv
// Parametrised add-compare-select array for a Viterbi decoder with saturating
// add, renormalisation, frame clear and a registered, warm-up-qualified best-state search.
module acs_unit_param #(
    parameter int K      = 3,
    parameter int BM_W   = 2,
    parameter int PM_W   = 6,
    parameter int WARMUP = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [(2**K)*BM_W-1:0]        i_bm,
    output logic                          o_valid,
    output logic [2**(K-1)-1:0]           o_dec,
    output logic [(2**(K-1))*PM_W-1:0]    o_pm,
    output logic                          o_best_valid,
    output logic [K-2:0]                  o_best_st,
    output logic [PM_W-1:0]               o_best_pm
);

    localparam int SW     = K - 1;
    localparam int NUM_ST = 1 << SW;
    localparam int NUM_T  = 2 * NUM_ST;
    localparam int CNT_W  = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [BM_W-1:0] bm_t;

    localparam pm_t              INIT_PM  = pm_t'(2 ** (PM_W - 2));
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WARMUP);

    pm_t              pm_q [NUM_ST];
    pm_t              pm_d [NUM_ST];
    logic [NUM_ST-1:0] dec_q, dec_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    best_st_q, best_st_d;
    pm_t              best_pm_q, best_pm_d;
    logic             best_valid_q, best_valid_d;

    bm_t              bm_arr [NUM_T];
    pm_t              acs_pm [NUM_ST];
    logic [NUM_ST-1:0] acs_dec;
    logic             acs_renorm;
    logic [SW-1:0]    srch_st;
    pm_t              srch_pm;

    function automatic pm_t sat_add(input pm_t a, input bm_t b);
        logic [PM_W:0] s;
        s = {1'b0, a} + (PM_W + 1)'(b);
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    always_comb begin
        for (int t = 0; t < NUM_T; t++) begin
            bm_arr[t] = i_bm[t*BM_W +: BM_W];
        end
    end

    // Predecessors of n are {n[SW-2:0], x}; the branch taken into n carries input bit n[SW-1].
    always_comb begin
        logic [SW-1:0] st;
        logic [SW:0]   pp0, pp1;
        logic [SW-1:0] p0, p1;
        pm_t           c0, c1;
        acs_renorm = 1'b1;
        acs_dec    = '0;
        for (int n = 0; n < NUM_ST; n++) begin
            st  = SW'(n);
            pp0 = {st, 1'b0};
            pp1 = {st, 1'b1};
            p0  = pp0[SW-1:0];
            p1  = pp1[SW-1:0];
            c0  = sat_add(pm_q[p0], bm_arr[{p0, st[SW-1]}]);
            c1  = sat_add(pm_q[p1], bm_arr[{p1, st[SW-1]}]);
            if (c1 < c0) begin
                acs_pm[n]  = c1;
                acs_dec[n] = 1'b1;
            end else begin
                acs_pm[n]  = c0;
            end
            acs_renorm = acs_renorm & acs_pm[n][PM_W-1];
        end
        if (acs_renorm) begin
            for (int n = 0; n < NUM_ST; n++) begin
                acs_pm[n][PM_W-1] = 1'b0;
            end
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        srch_st = '0;
        srch_pm = pm_q[0];
        for (int n = 1; n < NUM_ST; n++) begin
            if (pm_q[n] < srch_pm) begin
                srch_pm = pm_q[n];
                srch_st = SW'(n);
            end
        end
    end

    // NOTE: every _d gets a default before any branch so no latch can be inferred.
    always_comb begin
        pm_d         = pm_q;
        dec_d        = dec_q;
        valid_d      = 1'b0;
        cnt_d        = cnt_q;
        best_st_d    = best_st_q;
        best_pm_d    = best_pm_q;
        best_valid_d = 1'b0;
        if (i_clear) begin
            for (int n = 0; n < NUM_ST; n++) begin
                pm_d[n] = (n == 0) ? '0 : INIT_PM;
            end
            dec_d     = '0;
            cnt_d     = '0;
            best_st_d = '0;
            best_pm_d = '0;
        end else begin
            if (i_valid) begin
                pm_d    = acs_pm;
                dec_d   = acs_dec;
                valid_d = 1'b1;
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (valid_q) begin
                best_st_d    = srch_st;
                best_pm_d    = srch_pm;
                best_valid_d = (cnt_q == CNT_FULL);
            end
        end
    end

    // NOTE: the metric array is a small register file, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NUM_ST; n++) begin
                pm_q[n] <= (n == 0) ? '0 : INIT_PM;
            end
            dec_q        <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            best_st_q    <= '0;
            best_pm_q    <= '0;
            best_valid_q <= 1'b0;
        end else begin
            pm_q         <= pm_d;
            dec_q        <= dec_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            best_st_q    <= best_st_d;
            best_pm_q    <= best_pm_d;
            best_valid_q <= best_valid_d;
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_ST; n++) begin
            o_pm[n*PM_W +: PM_W] = pm_q[n];
        end
    end

    assign o_valid      = valid_q;
    assign o_dec        = dec_q;
    assign o_best_valid = best_valid_q;
    assign o_best_st    = best_st_q;
    assign o_best_pm    = best_pm_q;

endmodule
